// File: rtl/velocity_cell_pingpong_if.sv
// ============================================================================
//  Module   : velocity_cell_pingpong_if
//  Purpose  : Bundles the read, append and swap handshake signals of the
//             double-buffered per-cell velocity store.
//  Signals  : rd_en/rd_addr -> rd_data/rd_valid  (active-bank read)
//             wr_en/wr_data -> wr_ready          (shadow-bank append)
//             swap_req      -> swap_done         (bank exchange)
//             particle_count, overflow           (status)
//  Modports : master = client side (drives requests)
//             slave  = store side (velocity_cell_pingpong)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface velocity_cell_pingpong_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  swap_req;
  logic                  swap_done;
  logic [ADDR_WIDTH-1:0] particle_count;
  logic                  overflow;

  modport master (
    output rd_en, rd_addr, wr_en, wr_data, swap_req,
    input  rd_data, rd_valid, wr_ready, swap_done, particle_count, overflow
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_data, swap_req,
    output rd_data, rd_valid, wr_ready, swap_done, particle_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/velocity_cell_pingpong.sv
// ============================================================================
//  Module   : velocity_cell_pingpong
//  Purpose  : Double-buffered per-cell velocity store. Readers see the active
//             bank; new velocities are appended into the shadow bank; a swap
//             handshake exchanges the banks between iterations.
//             Entry layout {vz, vy, vx}, 32 bits each at the default width.
//  Ports    : clock   - system clock
//             rst_n   - asynchronous active-low reset
//             bus     - velocity_cell_pingpong_if.slave (read / append /
//                       swap handshake and status)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module velocity_cell_pingpong #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  wire logic                  clock,
  input  wire logic                  rst_n,
  velocity_cell_pingpong_if.slave    bus
);

  // Both banks live in one array; the bank select is the top address bit.
  localparam int                  DEPTH      = 2 ** (ADDR_WIDTH + 1);
  localparam logic [ADDR_WIDTH:0] C_PTR_FULL = (ADDR_WIDTH + 1)'(PARTICLE_NUM);
  localparam logic [ADDR_WIDTH:0] C_PTR_ONE  = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_SWAP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_sel;        // bank currently visible to readers
  logic [ADDR_WIDTH:0]   r_wr_ptr;     // one extra bit so "full" cannot wrap
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_overflow;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_idle;
  logic                  w_not_full;
  logic                  w_wr_ready;
  logic                  w_wr_accept;
  logic                  w_wr_drop;
  logic                  w_rd_accept;
  logic                  w_swap;
  logic [ADDR_WIDTH-1:0] w_shadow_count;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [DATA_WIDTH-1:0] w_count_ext;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign w_idle         = (r_state == S_IDLE);
  assign w_swap         = (r_state == S_SWAP);
  assign w_not_full     = (r_wr_ptr < C_PTR_FULL);
  assign w_wr_ready     = w_idle && w_not_full;
  assign w_wr_accept    = bus.wr_en && w_wr_ready;
  // Only a full shadow bank in IDLE flags overflow; DRAIN/SWAP drops are silent.
  assign w_wr_drop      = bus.wr_en && w_idle && !w_not_full;
  assign w_rd_accept    = bus.rd_en && w_idle;
  assign w_shadow_count = ADDR_WIDTH'(r_wr_ptr - C_PTR_ONE);
  assign w_ram_q        = r_mem[{r_sel, bus.rd_addr}];
  assign w_count_ext    = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, r_count};

  // --------------------------------------------------------------------------
  // FSM: IDLE -> DRAIN -> SWAP -> IDLE
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.swap_req) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_SWAP;
      S_SWAP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bank select, append pointer, active count, overflow flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sel      <= 1'b0;
      r_wr_ptr   <= C_PTR_ONE;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_swap) begin
      r_sel      <= ~r_sel;
      r_count    <= w_shadow_count;
      r_wr_ptr   <= C_PTR_ONE;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage: appends only ever target the shadow bank
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_wr_accept) begin
      r_mem[{~r_sel, r_wr_ptr[ADDR_WIDTH-1:0]}] <= bus.wr_data;
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port; address 0 reports the active particle count
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_data <= (bus.rd_addr == '0) ? w_count_ext : w_ram_q;
      end
    end
  end

  assign bus.rd_data        = r_rd_data;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.wr_ready       = w_wr_ready;
  assign bus.swap_done      = w_swap;
  assign bus.particle_count = r_count;
  assign bus.overflow       = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_velocity_cell_pingpong.sv
// ============================================================================
//  Module   : tb_velocity_cell_pingpong
//  Purpose  : Self-checking bench for velocity_cell_pingpong (PARTICLE_NUM=8)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_velocity_cell_pingpong;

  localparam int DW = 96;
  localparam int PN = 8;
  localparam int AW = 3;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_on = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  velocity_cell_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) vif ();

  velocity_cell_pingpong #(
    .DATA_WIDTH  (DW),
    .PARTICLE_NUM(PN),
    .ADDR_WIDTH  (AW)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (vif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: contents of the visible bank plus a queue of pending
  // appends; phase counts cycles since an accepted swap request.
  // --------------------------------------------------------------------------
  int          m_phase = 0;
  logic [DW-1:0] m_active [0:PN-1];
  logic [DW-1:0] m_shadow [$];
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  bit          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit          m_known = 1'b1;

  initial begin
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_count = 0; m_ovf = 0; m_valid = 0;
        m_data = '0; m_known = 1; m_shadow.delete();
      end else begin
        bit idle;
        idle = (m_phase == 0);
        if (idle && vif.rd_en) begin
          m_valid = 1;
          if (vif.rd_addr == 0) begin
            m_data = DW'(m_count); m_known = 1;
          end else if (int'(vif.rd_addr) <= m_count) begin
            m_data = m_active[vif.rd_addr]; m_known = 1;
          end else begin
            m_known = 0;
          end
        end else begin
          m_valid = 0;
        end
        if (idle && vif.wr_en) begin
          if (m_shadow.size() < PN - 1) m_shadow.push_back(vif.wr_data);
          else m_ovf = 1;
        end
        if (m_phase == 2) begin
          foreach (m_shadow[i]) m_active[i+1] = m_shadow[i];
          m_count = m_shadow.size();
          m_shadow.delete();
          m_ovf = 0;
          m_phase = 0;
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (idle && vif.swap_req) begin
          m_phase = 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (cmp_on) begin
        chk("rd_valid", DW'(vif.rd_valid), DW'(m_valid));
        if (m_known) chk("rd_data", vif.rd_data, m_data);
        chk("wr_ready", DW'(vif.wr_ready), DW'(m_phase == 0 && m_shadow.size() < PN - 1));
        chk("swap_done", DW'(vif.swap_done), DW'(m_phase == 2));
        chk("particle_count", DW'(vif.particle_count), DW'(m_count));
        chk("overflow", DW'(vif.overflow), DW'(m_ovf));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] d);
    vif.wr_en = 1'b1; vif.wr_data = d;
    tick();
    vif.wr_en = 1'b0;
  endtask

  task automatic do_read(input int a);
    vif.rd_en = 1'b1; vif.rd_addr = AW'(a);
    tick();
    vif.rd_en = 1'b0;
  endtask

  task automatic do_swap();
    int n;
    vif.swap_req = 1'b1;
    tick();
    vif.swap_req = 1'b0;
    n = 1;
    while (vif.swap_done !== 1'b1 && n < 6) begin
      tick();
      n++;
    end
    chk("swap_latency", DW'(n), DW'(2));
    tick();
  endtask

  initial begin
    vif.rd_en = 0; vif.rd_addr = '0; vif.wr_en = 0; vif.wr_data = '0; vif.swap_req = 0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Reset state and count read
    chk("rst_count", DW'(vif.particle_count), DW'(0));
    chk("rst_wr_ready", DW'(vif.wr_ready), DW'(1));
    chk("rst_rd_valid", DW'(vif.rd_valid), DW'(0));
    do_read(0);
    chk("t1_valid", DW'(vif.rd_valid), DW'(1));
    chk("t1_addr0", vif.rd_data, DW'(0));

    // First load and swap
    do_write(DW'(1)); do_write(DW'(2)); do_write(DW'(3));
    do_swap();
    chk("t2_count", DW'(vif.particle_count), DW'(3));
    do_read(1); chk("t2_addr1", vif.rd_data, DW'(1));
    do_read(2); chk("t2_addr2", vif.rd_data, DW'(2));
    do_read(3); chk("t2_addr3", vif.rd_data, DW'(3));
    do_read(0); chk("t2_addr0", vif.rd_data, DW'(3));

    // Shadow appends stay invisible until the next swap
    do_write(DW'('h11)); do_write(DW'('h12));
    do_read(1); do_read(2); do_read(3);
    chk("t3_old_addr3", vif.rd_data, DW'(3));
    do_swap();
    chk("t3_count", DW'(vif.particle_count), DW'(2));
    do_read(1); chk("t3_addr1", vif.rd_data, DW'('h11));
    do_read(2); chk("t3_addr2", vif.rd_data, DW'('h12));

    // Fill to capacity and overflow
    for (int i = 0; i < PN; i++) begin
      do_write(DW'('h100 + i));
      if (i == PN - 2) begin
        chk("t4_full_ready", DW'(vif.wr_ready), DW'(0));
        chk("t4_no_ovf_yet", DW'(vif.overflow), DW'(0));
      end
    end
    chk("t4_overflow", DW'(vif.overflow), DW'(1));
    do_swap();
    chk("t4_count", DW'(vif.particle_count), DW'(7));
    chk("t4_ovf_clear", DW'(vif.overflow), DW'(0));
    do_read(7); chk("t4_addr7", vif.rd_data, DW'('h106));

    // Same-cycle write + read + swap, then requests during DRAIN and SWAP
    vif.wr_en = 1; vif.wr_data = DW'('hAA); vif.rd_en = 1; vif.rd_addr = AW'(1); vif.swap_req = 1;
    tick();
    chk("t5_rd_old_valid", DW'(vif.rd_valid), DW'(1));
    chk("t5_rd_old_data", vif.rd_data, DW'('h100));
    vif.wr_data = DW'('hBB); vif.rd_addr = AW'(2);
    tick();
    chk("t5_drain_rd_valid", DW'(vif.rd_valid), DW'(0));
    chk("t5_swap_done", DW'(vif.swap_done), DW'(1));
    vif.wr_en = 0; vif.rd_en = 0;
    tick();
    vif.swap_req = 0;
    chk("t5_single_done", DW'(vif.swap_done), DW'(0));
    chk("t5_count", DW'(vif.particle_count), DW'(1));
    tick();
    chk("t5_no_second_done", DW'(vif.swap_done), DW'(0));
    do_read(1); chk("t5_addr1", vif.rd_data, DW'('hAA));

    // Reset while in SWAP
    for (int i = 0; i < PN; i++) do_write(DW'('h200 + i));
    vif.swap_req = 1; tick(); vif.swap_req = 0; tick();
    chk("t6_in_swap", DW'(vif.swap_done), DW'(1));
    chk("t6_ovf_before", DW'(vif.overflow), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_done", DW'(vif.swap_done), DW'(0));
    chk("t6_rst_count", DW'(vif.particle_count), DW'(0));
    chk("t6_rst_ovf", DW'(vif.overflow), DW'(0));
    chk("t6_rst_ready", DW'(vif.wr_ready), DW'(1));
    chk("t6_rst_rd_data", vif.rd_data, DW'(0));
    tick(); tick();
    rst_n = 1'b1;
    do_read(0); chk("t6_addr0", vif.rd_data, DW'(0));
    do_write(DW'('h77));
    do_swap();
    chk("t6_count", DW'(vif.particle_count), DW'(1));
    do_read(1); chk("t6_addr1", vif.rd_data, DW'('h77));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/velocity_cell_pingpong.md
Name: velocity_cell_pingpong

Overview:
- Parametrised, double-buffered per-cell velocity store. Successor to the single-bank per-cell velocity RAM.
- Readers (force evaluation, motion update) read the active bank. The motion-update unit appends new velocities into the shadow bank.
- A swap handshake exchanges the two banks at the end of each iteration. No read/write contention inside an iteration.
- Inferred RAM, no vendor IP, no init file. The initial load is done by writes followed by a swap.

Parameters:
- DATA_WIDTH, 96, bits per entry, MSB-LSB {vz, vy, vx}, 32 bits each.
- PARTICLE_NUM, 220, words per bank including address 0.
- ADDR_WIDTH, 8, address width. Must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request on the active bank.
- rd_addr  in  ADDR_WIDTH  read address. 0 = particle count; 1..PARTICLE_NUM-1 = particles.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  rd_data valid, exactly 1 cycle after an accepted rd_en.
- wr_en  in  1  append one velocity into the shadow bank.
- wr_data  in  DATA_WIDTH  velocity to append.
- wr_ready  out  1  shadow bank accepts writes this cycle.
- swap_req  in  1  single-cycle pulse requesting a bank exchange.
- swap_done  out  1  single-cycle pulse when the exchange completes.
- particle_count  out  ADDR_WIDTH  number of particles in the active bank.
- overflow  out  1  sticky: a write was dropped because the shadow bank was full.

Behaviour:
- **Reset (async, rst_n=0):**
  - sel=0 (bank0 active), wr_ptr=1, shadow count=0.
  - particle_count=0, rd_data=0, rd_valid=0, swap_done=0, overflow=0, wr_ready=1, FSM=IDLE.
  - RAM contents are not cleared.
  - Reset mid-swap or mid-write aborts immediately to the reset state.
- **Read path:**
  - rd_en is accepted only in IDLE; it is ignored in DRAIN and SWAP.
  - Latency is 1 cycle: rd_data and rd_valid update on the next edge.
  - rd_addr=0 returns particle_count zero-extended to DATA_WIDTH.
  - rd_addr >= particle_count+1 returns the RAM word; contents are don't-care but rd_valid is still asserted.
  - rd_data holds its last value when rd_valid=0.
- **Write path:**
  - wr_en && wr_ready writes wr_data to shadow[wr_ptr], then wr_ptr++.
  - Shadow count = wr_ptr-1.
  - wr_ready = (FSM==IDLE) && (wr_ptr < PARTICLE_NUM).
  - wr_en while the bank is full (wr_ptr==PARTICLE_NUM) in IDLE: write dropped, overflow<=1, wr_ptr unchanged.
  - wr_en in DRAIN/SWAP: dropped silently, overflow unaffected.
  - Writes never touch the active bank.
- **FSM IDLE -> DRAIN -> SWAP -> IDLE:**
  - IDLE: swap_req moves to DRAIN. A wr_en and/or rd_en in the same cycle is accepted first.
  - DRAIN (1 cycle): lets the final read complete. wr_ready=0.
  - SWAP (1 cycle):
    - sel<=~sel.
    - particle_count<=wr_ptr-1.
    - wr_ptr<=1, overflow<=0.
    - Next state IDLE, with swap_done=1 for that one cycle.
  - swap_req in DRAIN/SWAP is ignored; no queueing.
- **Swap timing:**
  - Swap latency from swap_req to swap_done is 2 cycles.
  - The first read after swap_done sees the new bank.
- **Swap with no writes:** a swap with zero writes yields particle_count=0. The old active bank becomes the shadow and its contents are overwritten on append.
- **Widths:** wr_ptr is ADDR_WIDTH+1 bits internally so the full condition does not wrap.

Test Plan:
- Reset, then read addr 0 -> rd_data=0, rd_valid=1 one cycle later; particle_count=0, wr_ready=1.
- Write 3 entries (0x..01, 0x..02, 0x..03), swap_req -> swap_done 2 cycles later; particle_count=3; reads of addrs 1..3 return the written values in order with 1-cycle latency; addr 0 returns 3.
- After the swap, write 2 new entries; reads of addrs 1..3 still return the old values. Second swap -> particle_count=2; addrs 1,2 return the new values.
- Write PARTICLE_NUM entries with PARTICLE_NUM=8:
  - the first 7 are accepted and wr_ready falls after the 7th;
  - the 8th is dropped and overflow=1;
  - swap -> particle_count=7, overflow=0.
- Same-cycle wr_en+rd_en+swap_req in IDLE -> write lands (count +1 after swap), read returns the old bank; rd_en during DRAIN gives rd_valid=0; swap_req during DRAIN gives a single swap_done.
- Assert rst_n low in the SWAP state -> all outputs at reset values immediately; sel=0; particle_count=0.
